// File: rtl/mem_arb.sv
// Two-requester memory arbiter: round-robin grant onto a shared memory port,
// with an in-order source-ID FIFO that steers memory responses back to their requester.
module mem_arb #(
    parameter int p_req_bits     = 77,
    parameter int p_resp_bits    = 77,
    parameter int p_max_inflight = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   req0_val,
    output logic                   req0_rdy,
    input  logic [p_req_bits-1:0]  req0_msg,

    input  logic                   req1_val,
    output logic                   req1_rdy,
    input  logic [p_req_bits-1:0]  req1_msg,

    output logic                   resp0_val,
    input  logic                   resp0_rdy,
    output logic [p_resp_bits-1:0] resp0_msg,

    output logic                   resp1_val,
    input  logic                   resp1_rdy,
    output logic [p_resp_bits-1:0] resp1_msg,

    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    output logic [p_req_bits-1:0]  mem_req_msg,

    input  logic                   mem_resp_val,
    output logic                   mem_resp_rdy,
    input  logic [p_resp_bits-1:0] mem_resp_msg
);

    localparam int ptr_bits = $clog2(p_max_inflight);
    localparam int cnt_bits = $clog2(p_max_inflight + 1);
    localparam logic [cnt_bits-1:0] cnt_max = cnt_bits'(p_max_inflight);

    logic                      prio;
    logic [cnt_bits-1:0]       cnt;
    logic [ptr_bits-1:0]       wptr;
    logic [ptr_bits-1:0]       rptr;
    logic [p_max_inflight-1:0] ids;

    logic full;
    logic empty;
    logic grant;
    logic head;
    logic req_xfer;
    logic resp_xfer;

    assign full  = (cnt == cnt_max);
    assign empty = (cnt == '0);

    // prio only breaks ties; a lone requester always wins
    assign grant = (req0_val & req1_val) ? prio : req1_val;

    assign mem_req_val = (req0_val | req1_val) & ~full;
    assign mem_req_msg = grant ? req1_msg : req0_msg;
    assign req0_rdy    = mem_req_rdy & ~full & ~grant;
    assign req1_rdy    = mem_req_rdy & ~full & grant;
    assign req_xfer    = mem_req_val & mem_req_rdy;

    assign head         = ids[rptr];
    assign resp0_val    = mem_resp_val & ~empty & ~head;
    assign resp1_val    = mem_resp_val & ~empty & head;
    assign resp0_msg    = mem_resp_msg;
    assign resp1_msg    = mem_resp_msg;
    assign mem_resp_rdy = ~empty & (head ? resp1_rdy : resp0_rdy);
    assign resp_xfer    = mem_resp_val & mem_resp_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= 1'b0;
            cnt  <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (req_xfer) begin
                wptr <= wptr + 1'b1;
                prio <= ~grant;
            end
            if (resp_xfer) begin
                rptr <= rptr + 1'b1;
            end
            case ({req_xfer, resp_xfer})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // ID storage needs no reset: entries are only read once cnt covers them
    always_ff @(posedge clk) begin
        if (req_xfer) begin
            ids[wptr] <= grant;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Randomized bench for mem_arb: queue-based reference model checked every cycle,
// an in-order memory model, an end-to-end response scoreboard and directed scenarios.
module tb_mem_arb;

    localparam int RB   = 77;
    localparam int SB   = 77;
    localparam int MAXI = 4;

    logic          clk;
    logic          rst;
    logic          req0_val, req0_rdy, req1_val, req1_rdy;
    logic [RB-1:0] req0_msg, req1_msg;
    logic          resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [SB-1:0] resp0_msg, resp1_msg;
    logic          mem_req_val, mem_req_rdy;
    logic [RB-1:0] mem_req_msg;
    logic          mem_resp_val, mem_resp_rdy;
    logic [SB-1:0] mem_resp_msg;

    mem_arb #(.p_req_bits(RB), .p_resp_bits(SB), .p_max_inflight(MAXI)) dut (
        .clk(clk), .rst(rst),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        else passed++;
    endtask

    function automatic logic [RB-1:0] rnd_msg();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[RB-1:0];
    endfunction

    // reference model state: outstanding source IDs in issue order, and the tie-break owner
    bit            q[$];
    bit            prio_m;
    // memory model and end-to-end scoreboard
    logic [RB-1:0] mq[$];
    int            mt[$];
    logic [SB-1:0] exp0[$], exp1[$];
    int            cyc = 0;
    int            lat = 1;
    bit            mem_hold = 0;
    int            acc0 = 0, acc1 = 0, racc0 = 0, racc1 = 0, r1v_seen = 0;
    int            glog[$];

    always begin
        bit any, full_m, empty_m, g, head, e_mrv, pop_m;
        @(negedge clk);
        if (!rst) begin
            q.delete(); prio_m = 0;
            mq.delete(); mt.delete(); exp0.delete(); exp1.delete();
        end
        any     = req0_val | req1_val;
        full_m  = (q.size() == MAXI);
        empty_m = (q.size() == 0);
        g       = (req0_val && req1_val) ? prio_m : req1_val;
        head    = empty_m ? 1'b0 : q[0];
        e_mrv   = any && !full_m;
        pop_m   = mem_resp_val && !empty_m && (head ? resp1_rdy : resp0_rdy);

        chk("mem_req_val", mem_req_val, e_mrv);
        chk("req0_rdy", req0_rdy, mem_req_rdy && !full_m && !g);
        chk("req1_rdy", req1_rdy, mem_req_rdy && !full_m && g);
        if (e_mrv) chk("mem_req_msg", mem_req_msg, g ? req1_msg : req0_msg);
        chk("resp0_val", resp0_val, mem_resp_val && !empty_m && !head);
        chk("resp1_val", resp1_val, mem_resp_val && !empty_m && head);
        chk("mem_resp_rdy", mem_resp_rdy, pop_m || (!empty_m && !mem_resp_val && (head ? resp1_rdy : resp0_rdy)));
        chk("resp0_msg", resp0_msg, mem_resp_msg);
        chk("resp1_msg", resp1_msg, mem_resp_msg);

        if (rst) begin
            if (pop_m) void'(q.pop_front());
            if (e_mrv && mem_req_rdy) begin
                q.push_back(g);
                prio_m = !g;
            end
            if (mem_req_val && mem_req_rdy) begin
                mq.push_back(mem_req_msg);
                mt.push_back(cyc);
                glog.push_back(req1_rdy ? 1 : 0);
                if (req1_rdy) begin exp1.push_back(~mem_req_msg); acc1++; end
                else begin exp0.push_back(~mem_req_msg); acc0++; end
            end
            if (resp0_val && resp0_rdy) begin
                chk("resp0_order", resp0_msg, (exp0.size() > 0) ? exp0[0] : ~resp0_msg);
                if (exp0.size() > 0) void'(exp0.pop_front());
                racc0++;
            end
            if (resp1_val && resp1_rdy) begin
                chk("resp1_order", resp1_msg, (exp1.size() > 0) ? exp1[0] : ~resp1_msg);
                if (exp1.size() > 0) void'(exp1.pop_front());
                racc1++;
            end
            if (mem_resp_val && mem_resp_rdy && mq.size() > 0) begin
                void'(mq.pop_front());
                void'(mt.pop_front());
            end
            if (resp1_val) r1v_seen++;
        end
        cyc++;
    end

    // in-order memory: head response becomes visible lat cycles after acceptance
    always @(posedge clk) begin
        #3;
        if (rst && mq.size() > 0 && !mem_hold && (cyc - mt[0]) >= lat) begin
            mem_resp_val = 1'b1;
            mem_resp_msg = ~mq[0];
        end else begin
            mem_resp_val = 1'b0;
            mem_resp_msg = rnd_msg();
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic idle_inputs();
        req0_val = 0; req1_val = 0;
        mem_req_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
        mem_hold = 0;
    endtask

    initial begin
        int a, rc;
        rst = 0;
        req0_msg = '0; req1_msg = '0;
        mem_resp_val = 0; mem_resp_msg = '0;
        idle_inputs();
        tick(2);
        #2;
        chk("rst_cnt", dut.cnt, 0);
        chk("rst_prio", dut.prio, 0);
        chk("rst_mem_resp_rdy", mem_resp_rdy, 0);
        chk("rst_resp0_val", resp0_val, 0);
        rst = 1;
        tick();

        // req0 alone: three requests, fastest memory
        lat = 1;
        a = acc0; rc = racc0; r1v_seen = 0;
        for (int i = 0; i < 3; i++) begin
            req0_val = 1; req0_msg = RB'(4 * i);
            tick();
        end
        req0_val = 0;
        tick(6);
        chk("solo_grants0", acc0 - a, 3);
        chk("solo_resp0", racc0 - rc, 3);
        chk("solo_resp1_val_seen", r1v_seen, 0);

        // both requesters: strict alternation from reset
        do_reset();
        glog.delete();
        req0_val = 1; req1_val = 1;
        for (int i = 0; i < 6; i++) begin
            req0_msg = rnd_msg(); req1_msg = rnd_msg();
            tick();
        end
        idle_inputs();
        tick(4);
        chk("rr_count", glog.size(), 6);
        for (int i = 0; i < 6; i++) chk("rr_grant", glog[i], i % 2);

        // memory withholds: fill, then one pop lets exactly one request in
        do_reset();
        mem_hold = 1;
        req0_val = 1; req1_val = 1;
        tick(6);
        mem_hold = 0;
        #2;
        chk("full_cnt", dut.cnt, 4);
        chk("full_req0_rdy", req0_rdy, 0);
        chk("full_req1_rdy", req1_rdy, 0);
        chk("full_pop_rdy", mem_resp_rdy, 1);
        a = acc0 + acc1;
        tick();
        mem_hold = 1;
        tick(3);
        chk("full_one_accept", acc0 + acc1 - a, 1);
        chk("full_cnt_again", dut.cnt, 4);
        idle_inputs();
        tick(8);

        // head ID 1 blocked by resp1_rdy
        do_reset();
        lat = 3;
        resp1_rdy = 0;
        req1_val = 1; req1_msg = rnd_msg();
        tick();
        req1_val = 0;
        rc = racc1;
        tick(8);
        #2;
        chk("blk_resp1_val", resp1_val, 1);
        chk("blk_mem_resp_rdy", mem_resp_rdy, 0);
        chk("blk_cnt", dut.cnt, 1);
        chk("blk_no_xfer", racc1 - rc, 0);
        resp1_rdy = 1;
        tick();
        #2;
        chk("blk_release_cnt", dut.cnt, 0);
        chk("blk_release_xfer", racc1 - rc, 1);

        // steady push+pop at cnt=2 across pointer wrap
        do_reset();
        lat = 2;
        req0_val = 1; req1_val = 1;
        for (int i = 0; i < 14; i++) begin
            req0_msg = rnd_msg(); req1_msg = rnd_msg();
            tick();
            if (i >= 2) chk("steady_cnt", dut.cnt, 2);
        end
        idle_inputs();
        tick(8);
        chk("steady_drain0", exp0.size(), 0);
        chk("steady_drain1", exp1.size(), 0);

        // asynchronous reset with three outstanding
        do_reset();
        lat = 1;
        mem_hold = 1;
        req0_val = 1;
        tick(3);
        req1_val = 1; mem_req_rdy = 0;
        chk("pre_rst_cnt", dut.cnt, 3);
        chk("pre_rst_prio", dut.prio, 1);
        #1;
        rst = 0;
        #1;
        chk("async_cnt", dut.cnt, 0);
        chk("async_prio", dut.prio, 0);
        chk("async_resp0_val", resp0_val, 0);
        chk("async_resp1_val", resp1_val, 0);
        chk("async_mem_resp_rdy", mem_resp_rdy, 0);
        chk("async_mem_req_val", mem_req_val, 1);
        tick(2);
        rst = 1;
        idle_inputs();
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 256 == 0) lat = $urandom_range(1, 4);
            if (i == 1500) do_reset();
            req0_val    = ($urandom % 3) != 0;
            req1_val    = ($urandom % 3) != 0;
            req0_msg    = rnd_msg();
            req1_msg    = rnd_msg();
            mem_req_rdy = ($urandom % 4) != 0;
            resp0_rdy   = ($urandom % 4) != 0;
            resp1_rdy   = ($urandom % 4) != 0;
            mem_hold    = ($urandom % 5) == 0;
            tick();
        end
        idle_inputs();
        tick(20);
        chk("final_drain0", exp0.size(), 0);
        chk("final_drain1", exp1.size(), 0);
        chk("final_cnt", dut.cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The module SHALL have parameter p_req_bits, default 77, meaning width of a memory request message, passed through unmodified.
REQ-002 The module SHALL have parameter p_resp_bits, default 77, meaning width of a memory response message, passed through unmodified.
REQ-003 The module SHALL have parameter p_max_inflight, default 4, meaning the maximum number of outstanding requests; it SHALL be a power of 2 and at least 2.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have ports req0_val (input, 1), req0_rdy (output, 1) and req0_msg (input, p_req_bits): requester 0 (fetch) request channel.
REQ-007 The module SHALL have ports req1_val (input, 1), req1_rdy (output, 1) and req1_msg (input, p_req_bits): requester 1 (data) request channel.
REQ-008 The module SHALL have ports resp0_val (output, 1), resp0_rdy (input, 1) and resp0_msg (output, p_resp_bits): requester 0 response channel.
REQ-009 The module SHALL have ports resp1_val (output, 1), resp1_rdy (input, 1) and resp1_msg (output, p_resp_bits): requester 1 response channel.
REQ-010 The module SHALL have ports mem_req_val (output, 1), mem_req_rdy (input, 1) and mem_req_msg (output, p_req_bits): shared memory request channel.
REQ-011 The module SHALL have ports mem_resp_val (input, 1), mem_resp_rdy (output, 1) and mem_resp_msg (input, p_resp_bits): shared memory response channel; memory responds in request order.

Function
REQ-012 All channels SHALL use val/rdy handshakes: a transfer occurs in the cycle where val and rdy are both 1.
REQ-013 The module SHALL hold state consisting of a 1-bit priority pointer prio, an inflight count cnt (0..p_max_inflight), and a source-ID FIFO of depth p_max_inflight, 1 bit per entry.
REQ-014 full SHALL be defined as cnt == p_max_inflight, and empty as cnt == 0.
REQ-015 Grant SHALL be combinational, with no added latency: if exactly one reqN_val is 1, grant N; if both are 1, grant prio.
REQ-016 mem_req_val SHALL equal (req0_val | req1_val) & !full.
REQ-017 mem_req_msg SHALL equal the granted requester's msg.
REQ-018 reqN_rdy SHALL equal mem_req_rdy & !full & (grant == N); the non-granted requester's rdy SHALL be 0.
REQ-019 On a request transfer, the granted ID SHALL be pushed to the FIFO tail, and prio SHALL become the complement of the granted ID (round-robin).
REQ-020 Without a request transfer, prio SHALL hold, including when only one requester is active.
REQ-021 Response routing SHALL use the FIFO head ID h: respH_val = mem_resp_val & !empty, respH_msg = mem_resp_msg, and the other resp val SHALL be 0.
REQ-022 mem_resp_rdy SHALL equal !empty & respH_rdy.
REQ-023 A response transfer SHALL pop the FIFO head.
REQ-024 With empty, mem_resp_rdy SHALL be 0 and both resp vals SHALL be 0.
REQ-025 A request transfer and a response transfer in the same cycle SHALL leave cnt unchanged, push the tail and pop the head.
REQ-026 When full, no new request SHALL be accepted; a response pop in the full cycle SHALL not unblock requests until the next cycle.
REQ-027 FIFO read and write pointers SHALL be log2(p_max_inflight) bits and wrap modulo depth.
REQ-028 resp msg outputs SHALL be driven from mem_resp_msg regardless of val; req msg SHALL be don't-care when mem_req_val is 0.
REQ-029 There SHALL be no combinational path from resp*_rdy to any req* signal, nor from mem_req_rdy to any resp* signal.

Reset
REQ-030 While rst is 0, prio SHALL be 0, cnt SHALL be 0, FIFO pointers SHALL be 0, and FIFO contents are don't-care.
REQ-031 Reset SHALL take effect asynchronously.
REQ-032 Consequently, during reset mem_req_val equals req0_val|req1_val, and mem_resp_rdy, resp0_val and resp1_val are 0.
REQ-033 Reset mid-operation SHALL discard all outstanding IDs; the environment SHALL also reset memory.

Verification
REQ-034 Only req0 issues addresses 0x0, 0x4, 0x8 with zero-delay memory: 3 grants to 0; responses appear on resp0 in order; resp1_val is never 1.
REQ-035 req0 and req1 both valid continuously for 6 cycles with mem_req_rdy=1 and responses drained: grant sequence 0,1,0,1,0,1.
REQ-036 Memory withholds responses and both requesters stay valid: after 4 accepts, cnt=4 and req0_rdy=req1_rdy=0; one response then lets exactly one new request be accepted on the following cycle.
REQ-037 Responses are delayed 3 cycles and resp1_rdy=0 for 5 cycles while the FIFO head is 1: mem_resp_rdy=0 and cnt stays unchanged; once resp1_rdy=1 the response transfers and the head advances.
REQ-038 Same-cycle request accept and response pop at cnt=2: cnt stays at 2 and routing order is preserved across pointer wrap (issue at least 9 requests).
REQ-039 Assert rst=0 asynchronously with cnt=3: cnt=0, prio=0 and resp vals=0 immediately, without waiting for a clk edge.
